dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_e      - responder FSM states (IDLE, WAIT, RESP)
//   LEGAL_WEA    - byte-enable patterns accepted when alignment checking
//                  is enabled (build macro DMEM_ALIGN_CHECK_EN)
//   wea_legal()  - membership test against LEGAL_WEA
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned N_LEGAL_WEA = 8;

  // read, single bytes, aligned halves, full word
  localparam logic [3:0] LEGAL_WEA [N_LEGAL_WEA] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic wea_legal(input logic [3:0] w);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL_WEA; i++) begin
      if (w == LEGAL_WEA[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 word RAM, byte-lane writable,
// registered read. Contents are not reset.
//   clk   - clock, rising edge
//   en    - perform an access this cycle
//   we    - byte-lane write enables; 4'b0000 with en = read
//   addr  - word address
//   wdata - write data (lane aligned)
//   rdata - read word; updates only on a read, holds otherwise
module dmem_array #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == '0) rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the memory stage.
// Accepts one request in IDLE, waits LATENCY-1 cycles in WAIT, performs the
// access on the edge into RESP and pulses resp_valid for one cycle.
//   Parameters: DEPTH (words, power of two), LATENCY (1..15)
//   clk, reset (async, active low)
//   req_valid, wea, addr, wdata   - request (wea == 0 means read)
//   req_ready                     - request accepted this cycle (IDLE)
//   rdata                         - last read word (0 after reset/error)
//   resp_valid                    - one-cycle completion pulse
//   stall                         - hold pipeline: (IDLE & req_valid) | WAIT
//   addr_err                      - illegal byte-enable pattern, with resp_valid
// Build option: DMEM_ALIGN_CHECK_EN enables byte-enable pattern checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        addr_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wea_q, wea_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          rd_zero_q, rd_zero_d;

  logic          exec;
  logic          acc_bad;
  logic          acc_from_port;
  logic [AW-1:0] acc_addr;
  logic [3:0]    acc_wea;
  logic [31:0]   acc_wdata;
  logic [31:0]   arr_rdata;

  // Byte-offset and wrap-around address bits take no part in the access.
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // With LATENCY=1 the access runs on the accept edge, straight from the ports.
  assign acc_from_port = (state_q == IDLE);
  assign acc_addr      = acc_from_port ? addr[AW+1:2] : addr_q;
  assign acc_wea       = acc_from_port ? wea          : wea_q;
  assign acc_wdata     = acc_from_port ? wdata        : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_bad = !wea_legal(acc_wea);
`else
  assign acc_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wea_d     = wea_q;
    wdata_d   = wdata_q;
    exec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = addr[AW+1:2];
          wea_d   = wea;
          wdata_d = wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            exec    = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Access fires on the edge where the counter reaches zero, which
        // keeps resp_valid exactly LATENCY cycles after the accept cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          exec    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d     = exec & acc_bad;
    rd_zero_d = rd_zero_q;
    if (exec) begin
      if (acc_bad)             rd_zero_d = 1'b1;
      else if (acc_wea == '0)  rd_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wea_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wea_q     <= wea_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (exec & ~acc_bad),
    .we    (acc_wea),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The array read register is not reset; a flag masks it to zero after
  // reset or an illegal access until the next good read completes.
  assign rdata      = rd_zero_q ? '0 : arr_rdata;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign stall      = (state_q == IDLE && req_valid) || (state_q == WAIT);
  assign addr_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, resp_valid, stall, addr_err;
  logic [3:0]  wea;
  logic [31:0] addr, wdata, rdata;

  logic        req_valid1, req_ready1, resp_valid1, stall1, addr_err1;
  logic [3:0]  wea1;
  logic [31:0] addr1, wdata1, rdata1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] word10;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .wea        (wea),
    .addr       (addr),
    .wdata      (wdata),
    .req_ready  (req_ready),
    .rdata      (rdata),
    .resp_valid (resp_valid),
    .stall      (stall),
    .addr_err   (addr_err)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid1),
    .wea        (wea1),
    .addr       (addr1),
    .wdata      (wdata1),
    .req_ready  (req_ready1),
    .rdata      (rdata1),
    .resp_valid (resp_valid1),
    .stall      (stall1),
    .addr_err   (addr_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One LATENCY=2 transaction: accept cycle, one WAIT cycle, RESP, then idle.
  task automatic l2_access(input string tag, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    req_valid = 1'b1; wea = w; addr = a; wdata = d;
    #1;
    check_eq({tag, "/acc_ready"}, req_ready, 1);
    check_eq({tag, "/acc_stall"}, stall, 1);
    check_eq({tag, "/acc_resp"}, resp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0; wea = '0; wdata = '0;
    #1;
    check_eq({tag, "/wait_stall"}, stall, 1);
    check_eq({tag, "/wait_resp"}, resp_valid, 0);
    @(negedge clk);
    #1;
    check_eq({tag, "/resp_valid"}, resp_valid, 1);
    check_eq({tag, "/resp_stall"}, stall, 0);
    check_eq({tag, "/resp_ready"}, req_ready, 0);
    check_eq({tag, "/addr_err"}, addr_err, 32'(exp_err));
    check_eq({tag, "/rdata"}, rdata, exp_rd);
    @(negedge clk);
    #1;
    check_eq({tag, "/post_resp"}, resp_valid, 0);
    check_eq({tag, "/post_err"}, addr_err, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; wea = '0; addr = '0; wdata = '0;
    req_valid1 = 1'b0; wea1 = '0; addr1 = '0; wdata1 = '0;
    #2;
    check_eq("rst/rdata", rdata, 0);
    check_eq("rst/resp", resp_valid, 0);
    check_eq("rst/err", addr_err, 0);
    check_eq("rst/ready", req_ready, 1);
    check_eq("rst/stall", stall, 0);
    check_eq("rst1/rdata", rdata1, 0);
    check_eq("rst1/resp", resp_valid1, 0);
    @(negedge clk);
    reset = 1'b1;

    // full word write, then read back
    l2_access("wr_full", 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    l2_access("rd_full", 4'b0000, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    // single-lane write leaves rdata alone, read shows merge
    l2_access("wr_byte2", 4'b0100, 32'h10, 32'h00AA0000, 1'b0, 32'hDEADBEEF);
    l2_access("rd_byte2", 4'b0000, 32'h10, 32'h0, 1'b0, 32'hDEAABEEF);
    // address 0x1000 is word 1024, wraps to word 0
    l2_access("wr_wrap", 4'b1111, 32'h1000, 32'h12345678, 1'b0, 32'hDEAABEEF);
    l2_access("rd_wrap", 4'b0000, 32'h0, 32'h0, 1'b0, 32'h12345678);

`ifdef DMEM_ALIGN_CHECK_EN
    l2_access("wr_0101", 4'b0101, 32'h10, 32'h11223344, 1'b1, 32'h0);
    word10 = 32'hDEAABEEF;
`else
    l2_access("wr_0101", 4'b0101, 32'h10, 32'h11223344, 1'b0, 32'h12345678);
    word10 = 32'hDE22BE44;
`endif
    l2_access("rd_0101", 4'b0000, 32'h10, 32'h0, 1'b0, word10);

    // reset in the middle of WAIT abandons the write
    @(negedge clk);
    req_valid = 1'b1; wea = 4'b1111; addr = 32'h10; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0; wea = '0; wdata = '0;
    #1;
    check_eq("rstwait/stall_wait", stall, 1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rstwait/resp", resp_valid, 0);
    check_eq("rstwait/stall", stall, 0);
    check_eq("rstwait/rdata", rdata, 0);
    check_eq("rstwait/err", addr_err, 0);
    check_eq("rstwait/ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    l2_access("rd_after_rst", 4'b0000, 32'h10, 32'h0, 1'b0, word10);

    // LATENCY=1 with req_valid held high: IDLE/RESP alternate
    @(negedge clk);
    req_valid1 = 1'b1; wea1 = 4'b1111; addr1 = 32'h20; wdata1 = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("l1/resp%0d", i), resp_valid1, 32'(i % 2));
      check_eq($sformatf("l1/ready%0d", i), req_ready1, 32'(1 - (i % 2)));
      check_eq($sformatf("l1/stall%0d", i), stall1, 32'(1 - (i % 2)));
      check_eq($sformatf("l1/rdata%0d", i), rdata1, 0);
      @(negedge clk);
    end
    wea1 = 4'b0000;
    #1;
    check_eq("l1/rd_ready", req_ready1, 1);
    @(negedge clk);
    req_valid1 = 1'b0;
    #1;
    check_eq("l1/rd_resp", resp_valid1, 1);
    check_eq("l1/rd_data", rdata1, 32'hA5A5A5A5);
    check_eq("l1/rd_err", addr_err1, 0);
    @(negedge clk);
    #1;
    check_eq("l1/idle_resp", resp_valid1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
